// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
// Helpers turn a requester index into a one-hot grant or a below-index mask.
package arb_pkg;

  localparam int ARB_N   = 8;
  localparam int ARB_IDW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  function automatic logic [ARB_N-1:0] id_to_onehot(input logic [ARB_IDW-1:0] id);
    return ARB_N'(1) << id;
  endfunction

  // All requester bits strictly below id; empty for id 0.
  function automatic logic [ARB_N-1:0] below_mask(input logic [ARB_IDW-1:0] id);
    return (ARB_N'(1) << id) - ARB_N'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
// The grant side also feeds the downstream resource mux select.
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic [ARB_N-1:0]   req;
  logic               lock;
  logic [ARB_N-1:0]   gnt;
  logic [ARB_IDW-1:0] gnt_id;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req,
    output lock,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  lock,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/priority_encoder_8to3.sv
// Eight-to-three priority encoder; the highest set index wins.
// any is low when no input bit is set, in which case idx is 0.
module priority_encoder_8to3
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]   vec,
  output logic [ARB_IDW-1:0] idx,
  output logic               any
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (vec[i]) idx = ARB_IDW'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with hold-until-release grants and a bounded tenure.
// Rotation runs downward from the last granted index; all outputs are registered.
//
// state | meaning
// IDLE  | no grant; any request is granted on the next edge
// GRANT | grant held; ends on owner release or hold-limit timeout
// GAP   | one forced grant-free cycle; its exit decision is the IDLE decision
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_8_if.slave bus
);

  localparam int CW_RAW = $clog2(MAX_HOLD + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit            LIMIT_EN  = (MAX_HOLD != 0);

  arb_state_t state;
  arb_state_t state_nxt;

  logic [ARB_N-1:0]   gnt_q;
  logic [ARB_N-1:0]   gnt_nxt;
  logic [ARB_IDW-1:0] gnt_id_q;
  logic [ARB_IDW-1:0] gnt_id_nxt;
  logic [ARB_IDW-1:0] last_id;
  logic [ARB_IDW-1:0] last_id_nxt;
  logic [CW-1:0]      hold_cnt;
  logic [CW-1:0]      hold_cnt_nxt;
  logic               gnt_valid_q;
  logic               timeout_q;
  logic               timeout_nxt;

  logic [ARB_N-1:0]   low;
  logic [ARB_IDW-1:0] low_id;
  logic [ARB_IDW-1:0] all_id;
  logic [ARB_IDW-1:0] win_id;
  logic               low_any;
  logic               all_any;
  logic               owner_req;
  logic               limit_hit;
  logic               tenure_end;
  logic               load_grant;

  assign low = bus.req & below_mask(last_id);

  priority_encoder_8to3 u_enc_low (
    .vec (low),
    .idx (low_id),
    .any (low_any)
  );

  priority_encoder_8to3 u_enc_all (
    .vec (bus.req),
    .idx (all_id),
    .any (all_any)
  );

  // Prefer the highest requester below last_id, else wrap to the highest overall.
  assign win_id = low_any ? low_id : all_id;

  // hold_cnt may sit above HOLD_LAST while lock is high, so the check is >=.
  assign owner_req  = bus.req[gnt_id_q];
  assign limit_hit  = LIMIT_EN && !bus.lock && (hold_cnt >= HOLD_LAST);
  assign tenure_end = (state == GRANT) && (!owner_req || limit_hit);
  assign load_grant = (state != GRANT) && all_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, GAP: state_nxt = all_any ? GRANT : IDLE;
      GRANT:     if (tenure_end) state_nxt = GAP;
      default:   state_nxt = IDLE;
    endcase
  end

  // Release wins a same-cycle collision: timeout only flags a cut with the owner still requesting.
  always_comb begin
    gnt_nxt      = gnt_q;
    gnt_id_nxt   = gnt_id_q;
    last_id_nxt  = last_id;
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE, GAP: begin
        gnt_nxt = '0;
        if (load_grant) begin
          gnt_nxt      = id_to_onehot(win_id);
          gnt_id_nxt   = win_id;
          hold_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (tenure_end) begin
          gnt_nxt     = '0;
          last_id_nxt = gnt_id_q;
          timeout_nxt = owner_req;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_id     <= '0;
      hold_cnt    <= '0;
    end else begin
      gnt_q       <= gnt_nxt;
      gnt_id_q    <= gnt_id_nxt;
      gnt_valid_q <= |gnt_nxt;
      timeout_q   <= timeout_nxt;
      last_id     <= last_id_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Drives three arbiters (MAX_HOLD 2, 3, 4) with one shared stimulus and checks them
// against a tenure-level reference model, plus a vector table and directed sequences.
module tb_rr_arbiter_8;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       lock = 1'b0;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_8_if bus2 ();
  rr_arbiter_8_if bus3 ();
  rr_arbiter_8_if bus4 ();

  assign bus2.req = req;
  assign bus2.lock = lock;
  assign bus3.req = req;
  assign bus3.lock = lock;
  assign bus4.req = req;
  assign bus4.lock = lock;

  rr_arbiter_8 #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  rr_arbiter_8 #(.MAX_HOLD(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  logic [7:0] d_gnt [3];
  logic [2:0] d_id  [3];
  logic       d_v   [3];
  logic       d_to  [3];

  always_comb begin
    d_gnt[0] = bus2.gnt; d_id[0] = bus2.gnt_id; d_v[0] = bus2.gnt_valid; d_to[0] = bus2.timeout;
    d_gnt[1] = bus3.gnt; d_id[1] = bus3.gnt_id; d_v[1] = bus3.gnt_valid; d_to[1] = bus3.timeout;
    d_gnt[2] = bus4.gnt; d_id[2] = bus4.gnt_id; d_v[2] = bus4.gnt_valid; d_to[2] = bus4.timeout;
  end

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut_idx=%0d actual=%0h expected=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, for how many cycles, and who went last.
  int m_mh [3] = '{2, 3, 4};
  bit m_busy  [3];
  int m_owner [3];
  int m_last  [3];
  int m_cnt   [3];
  bit m_to    [3];

  function automatic int pick(input logic [7:0] r, input int last);
    for (int i = last - 1; i >= 0; i--) if (r[i]) return i;
    for (int i = 7; i >= 0; i--) if (r[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] <= 1'b0; m_owner[k] <= 0; m_last[k] <= 0; m_cnt[k] <= 0; m_to[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_to[k] <= 1'b0;
        if (m_busy[k]) begin
          if (!req[m_owner[k]]) begin
            m_busy[k] <= 1'b0;
            m_last[k] <= m_owner[k];
          end else if (m_mh[k] != 0 && !lock && m_cnt[k] >= m_mh[k]) begin
            m_busy[k] <= 1'b0;
            m_last[k] <= m_owner[k];
            m_to[k]   <= 1'b1;
          end else begin
            m_cnt[k] <= m_cnt[k] + 1;
          end
        end else if (req != 8'h00) begin
          m_owner[k] <= pick(req, m_last[k]);
          m_busy[k]  <= 1'b1;
          m_cnt[k]   <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        check("mon_gnt", k, 32'(d_gnt[k]), m_busy[k] ? (32'd1 << m_owner[k]) : 32'd0);
        check("mon_valid", k, 32'(d_v[k]), 32'(m_busy[k]));
        check("mon_timeout", k, 32'(d_to[k]), 32'(m_to[k]));
        if (m_busy[k]) check("mon_gnt_id", k, 32'(d_id[k]), 32'(m_owner[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string name, input int k, input logic [7:0] g, input logic [2:0] id,
                            input logic to);
    check({name, "_gnt"}, k, 32'(d_gnt[k]), 32'(g));
    check({name, "_valid"}, k, 32'(d_v[k]), 32'(g != 8'h00));
    check({name, "_timeout"}, k, 32'(d_to[k]), 32'(to));
    if (g != 8'h00) check({name, "_gnt_id"}, k, 32'(d_id[k]), 32'(id));
  endtask

  typedef struct {
    logic [7:0] req;
    logic       lock;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       to;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b0};
    tbl[2]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b0};
    tbl[3]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[4]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b0};
    tbl[5]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[6]  = '{8'h88, 1'b0, 8'h80, 3'd7, 1'b0};
    tbl[7]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[8]  = '{8'h88, 1'b0, 8'h08, 3'd3, 1'b0};
    tbl[9]  = '{8'h88, 1'b1, 8'h08, 3'd3, 1'b0};
    tbl[10] = '{8'h80, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[11] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b0};
    tbl[12] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};

    // Reset values on every instance.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_gnt", k, 32'(d_gnt[k]), 32'd0);
      check("rst_gnt_id", k, 32'(d_id[k]), 32'd0);
      check("rst_valid", k, 32'(d_v[k]), 32'd0);
      check("rst_timeout", k, 32'(d_to[k]), 32'd0);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single requester, wrap and mask, side requests ignored (MAX_HOLD=4 instance).
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      lock = tbl[i].lock;
      step();
      expect_out($sformatf("tbl%0d", i), 2, tbl[i].gnt, tbl[i].id, tbl[i].to);
    end

    // Rotation with all requesters active: 7,6,...,0,7, 2-cycle tenures, 1 gap, timeout each time.
    do_reset();
    req = 8'hFF;
    for (int t = 0; t < 9; t++) begin
      logic [2:0] id;
      id = 3'((15 - t) % 8);
      step();
      expect_out("rot_c1", 0, 8'(8'd1 << id), id, 1'b0);
      step();
      expect_out("rot_c2", 0, 8'(8'd1 << id), id, 1'b0);
      step();
      expect_out("rot_gap", 0, 8'h00, 3'd0, 1'b1);
    end

    // Release on the 4th grant cycle beats the timeout.
    do_reset();
    req = 8'h01;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_out("coll_hold", 2, 8'h01, 3'd0, 1'b0);
    end
    req = 8'h00;
    step();
    expect_out("coll_release", 2, 8'h00, 3'd0, 1'b0);

    // Same tenure left alone is cut after exactly 4 cycles.
    do_reset();
    req = 8'h01;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_out("limit_hold", 2, 8'h01, 3'd0, 1'b0);
    end
    step();
    expect_out("limit_cut", 2, 8'h00, 3'd0, 1'b1);
    req = 8'h00;
    step();

    // Lock suppresses the limit; dropping it late fires the timeout at once.
    do_reset();
    lock = 1'b1;
    req = 8'h01;
    for (int c = 0; c < 10; c++) begin
      step();
      expect_out("lock_hold", 1, 8'h01, 3'd0, 1'b0);
    end
    lock = 1'b0;
    step();
    expect_out("lock_drop", 1, 8'h00, 3'd0, 1'b1);
    req = 8'h00;
    step();

    // Async reset mid-tenure; rotation restarts from index 0 afterwards.
    do_reset();
    req = 8'h02;
    step();
    expect_out("ar_first", 0, 8'h02, 3'd1, 1'b0);
    req = 8'h00;
    step();
    req = 8'h80;
    step();
    expect_out("ar_wrap", 0, 8'h80, 3'd7, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("ar_gnt_drop", k, 32'(d_gnt[k]), 32'd0);
      check("ar_valid_drop", k, 32'(d_v[k]), 32'd0);
    end
    req = 8'h03;
    #1;
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) expect_out("ar_restart", k, 8'h02, 3'd1, 1'b0);
    req = 8'h00;
    step();

    // Random traffic: sticky request bits and lock toggling, checked by the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 15) == 0) lock = ~lock;
      step();
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
